hbridge_guard: RTL and testbench
================================

Name: hbridge_guard

Overview:
- Sits between the switch-driven motor command logic and the dual H-bridge pins; it receives the 4-bit IN command word and produces the protected IN word actually driven to the bridge.
- Per channel, it enforces dead-time on direction reversal and blanks, filters and latches the bridge's overcurrent comparator input.
- A latched fault forces coast, then holds off a retry timer before the channel re-arms.

Parameters:
- DEAD_CYCLES, 50: coast cycles inserted on a forward/reverse reversal (1 us at 50 MHz).
- BLANK_CYCLES, 500: cycles after the drive starts during which oc is ignored.
- OC_FILT, 8: consecutive cycles oc must stay high to trip.
- RETRY_CYCLES, 5000000: fault hold-off time (100 ms).

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- in_cmd  in  4  commanded IN; [1:0] channel A, [3:2] channel B.
- oc  in  2  overcurrent comparator, [0]=A, [1]=B; asynchronous to clk.
- IN  out  4  protected H-bridge inputs, registered.
- fault  out  2  latched fault per channel.
- busy  out  2  per channel: in DEAD or HOLD state.

Behaviour:
- Channel pair encoding: 10 = forward, 01 = reverse, 00 = coast, 11 = brake.
- oc is double-flop synchronised (2-cycle latency) before any use.
- Reset (reset=0, async): IN=0000, fault=00, busy=00, all counters 0, both FSMs IDLE.
- Channels are fully independent; FSM per channel has states IDLE, DRIVE, DEAD, FAULT, HOLD.
- IDLE:
  - Output = cmd when cmd is 00 or 11.
  - On cmd=10 or 01: latch as last_dir, load blank counter, go to DRIVE.
  - Output registered, 1-cycle latency from in_cmd to IN.
- DRIVE:
  - Output = cmd.
  - cmd equal to last_dir: stay.
  - cmd = opposite direction: go to DEAD, output 00, load dead counter.
  - cmd = 00 or 11: go to IDLE with that output.
  - Blank counter decrements to 0; while nonzero, the filter counter is held at 0.
  - After blanking, filter counter increments while synced oc=1 and clears on oc=0.
  - Reaching OC_FILT: go to FAULT.
- DEAD:
  - Output 00 for exactly DEAD_CYCLES cycles, regardless of further cmd changes.
  - Then sample the current cmd: direction goes to DRIVE (blank reloaded); 00/11 goes to IDLE.
  - oc is ignored in DEAD.
- FAULT (1 cycle): output 00, set fault bit, load retry counter, go to HOLD.
- HOLD:
  - Output 00, fault stays 1, retry counter decrements.
  - At 0, if cmd is 00 or 11: clear fault, go to IDLE.
  - At 0 with a direction command: remain in HOLD (counter stays 0) until the operator returns to coast or brake, so there is no auto-restart.
- Simultaneous oc trip and reversal in the same cycle: fault wins.
- Counter widths: each is $clog2(param+1); counters never wrap and saturate at 0.
- An asynchronous reset mid-DEAD or mid-HOLD returns the channel immediately to the reset values.

Optional Feature:
- Macro: HBRIDGE_FAULT_COUNT_EN.
- When defined:
  - Adds output fault_cnt [15:0]: [7:0] for A, [15:8] for B.
  - Each byte increments on the channel's DRIVE-to-FAULT transition and saturates at 255.
  - Cleared only by reset.
- When undefined: the port and its counters are absent; all other behaviour is identical.

Decomposition:
- Package hbridge_pkg holds:
  - Localparams CMD_COAST=2'b00, CMD_REV=2'b01, CMD_FWD=2'b10, CMD_BRAKE=2'b11.
  - The state encoding IDLE/DRIVE/DEAD/FAULT/HOLD.
- Sub-module hbridge_channel implements one FSM with its counters and synchroniser.
- hbridge_guard instantiates it twice and concatenates the outputs.

Test Plan:
Bench uses DEAD_CYCLES=4, BLANK_CYCLES=8, OC_FILT=3, RETRY_CYCLES=20, 20 ns clk.
- Reset check: reset=0 with in_cmd=1010 and oc=11 -> IN=0000, fault=00 while low. Release reset -> IN=1010 one cycle later.
- Reversal: A at 10, then in_cmd[1:0]=01 -> IN[1:0]=00 for exactly 4 cycles, busy[0]=1, then 01. Channel B is undisturbed.
- Blanking: oc[0]=1 for 6 cycles immediately after IN[1:0] becomes 10 -> no fault.
- Filter and trip: after blanking, oc[0]=1 for 2 cycles then 0 -> no fault. oc[0]=1 held -> fault[0]=1 and IN[1:0]=00 on the 3rd synced-high cycle + 1.
- Retry: cmd held at 10 -> stays faulted past 20 cycles. cmd=00 -> fault[0] clears and IN[1:0]=00. cmd=10 -> drives again.
- With HBRIDGE_FAULT_COUNT_EN, 3 trips on B -> fault_cnt[15:8]=3 and [7:0]=0. Reset mid-HOLD -> all outputs 0, count 0.

Source files
------------

// File: rtl/hbridge_pkg.sv
// hbridge_pkg: shared command encodings, channel state encoding and command helpers
package hbridge_pkg;
  localparam logic [1:0] CMD_COAST = 2'b00;
  localparam logic [1:0] CMD_REV   = 2'b01;
  localparam logic [1:0] CMD_FWD   = 2'b10;
  localparam logic [1:0] CMD_BRAKE = 2'b11;
  typedef enum logic [2:0] {IDLE, DRIVE, DEAD, FAULT, HOLD} state_t;
  function automatic logic is_dir(input logic [1:0] c);
    return c == CMD_FWD || c == CMD_REV;
  endfunction
  function automatic logic is_stop(input logic [1:0] c);
    return c == CMD_COAST || c == CMD_BRAKE;
  endfunction
endpackage

// File: rtl/hbridge_channel.sv
// hbridge_channel: one bridge channel with dead-time, oc blanking/filtering and fault hold-off (HBRIDGE_FAULT_COUNT_EN adds a trip counter)
module hbridge_channel
  import hbridge_pkg::*;
#(
  parameter int DEAD_CYCLES  = 50,
  parameter int BLANK_CYCLES = 500,
  parameter int OC_FILT      = 8,
  parameter int RETRY_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] cmd,
  input  logic       oc,
  output logic [1:0] out,
  output logic       fault,
  output logic       busy
`ifdef HBRIDGE_FAULT_COUNT_EN
  ,
  output logic [7:0] fault_cnt
`endif
);
  localparam int DW = $clog2(DEAD_CYCLES + 1);
  localparam int BW = $clog2(BLANK_CYCLES + 1);
  localparam int FW = $clog2(OC_FILT + 1);
  localparam int RW = $clog2(RETRY_CYCLES + 1);
  state_t state, state_n;
  logic [1:0] out_n, dir, dir_n, oc_sync;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [FW-1:0] fcnt, fcnt_n;
  logic [RW-1:0] rcnt, rcnt_n;
  logic oc_s, trip;
  assign oc_s  = oc_sync[1];
  assign trip  = state == DRIVE && bcnt == '0 && oc_s && fcnt == FW'(OC_FILT - 1);
  assign fault = state == FAULT || state == HOLD;
  assign busy  = state == DEAD || state == HOLD;
  // oc arrives asynchronously, so it passes two flops before anything looks at it
  always_ff @(posedge clk or negedge reset)
    if (!reset) oc_sync <= '0;
    else oc_sync <= {oc_sync[0], oc};
  // next state, next pin value and counter updates; a trip outranks any command change
  always_comb begin
    state_n = state;
    out_n   = out;
    dir_n   = dir;
    dcnt_n  = dcnt;
    bcnt_n  = bcnt;
    fcnt_n  = '0;
    rcnt_n  = rcnt;
    case (state)
      IDLE: begin
        out_n = cmd;
        if (is_dir(cmd)) begin
          state_n = DRIVE;
          dir_n   = cmd;
          bcnt_n  = BW'(BLANK_CYCLES);
        end
      end
      DRIVE: begin
        out_n  = cmd;
        bcnt_n = (bcnt == '0) ? '0 : bcnt - BW'(1);
        fcnt_n = (bcnt == '0 && oc_s) ? fcnt + FW'(1) : '0;
        if (trip) begin
          state_n = FAULT;
          out_n   = CMD_COAST;
        end else if (is_stop(cmd)) begin
          state_n = IDLE;
        end else if (cmd != dir) begin
          state_n = DEAD;
          out_n   = CMD_COAST;
          dcnt_n  = DW'(DEAD_CYCLES);
        end
      end
      DEAD: begin
        out_n  = CMD_COAST;
        dcnt_n = (dcnt == '0) ? '0 : dcnt - DW'(1);
        if (dcnt <= DW'(1)) begin
          out_n   = cmd;
          state_n = is_dir(cmd) ? DRIVE : IDLE;
          dir_n   = is_dir(cmd) ? cmd : dir;
          bcnt_n  = BW'(BLANK_CYCLES);
        end
      end
      FAULT: begin
        out_n   = CMD_COAST;
        rcnt_n  = RW'(RETRY_CYCLES);
        state_n = HOLD;
      end
      HOLD: begin
        out_n  = CMD_COAST;
        rcnt_n = (rcnt == '0) ? '0 : rcnt - RW'(1);
        if (rcnt == '0 && is_stop(cmd)) begin
          state_n = IDLE;
          out_n   = cmd;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  // state, registered pin drive and counters
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      out   <= '0;
      dir   <= '0;
      dcnt  <= '0;
      bcnt  <= '0;
      fcnt  <= '0;
      rcnt  <= '0;
    end else begin
      state <= state_n;
      out   <= out_n;
      dir   <= dir_n;
      dcnt  <= dcnt_n;
      bcnt  <= bcnt_n;
      fcnt  <= fcnt_n;
      rcnt  <= rcnt_n;
    end
`ifdef HBRIDGE_FAULT_COUNT_EN
  // saturating count of DRIVE-to-FAULT trips, cleared only by reset
  always_ff @(posedge clk or negedge reset)
    if (!reset) fault_cnt <= '0;
    else if (trip && fault_cnt != 8'hff) fault_cnt <= fault_cnt + 8'd1;
`endif
endmodule

// File: rtl/hbridge_guard.sv
// hbridge_guard: dual H-bridge protection, two independent channels (HBRIDGE_FAULT_COUNT_EN adds fault_cnt)
module hbridge_guard
  import hbridge_pkg::*;
#(
  parameter int DEAD_CYCLES  = 50,
  parameter int BLANK_CYCLES = 500,
  parameter int OC_FILT      = 8,
  parameter int RETRY_CYCLES = 5000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  in_cmd,
  input  logic [1:0]  oc,
  output logic [3:0]  IN,
  output logic [1:0]  fault,
  output logic [1:0]  busy
`ifdef HBRIDGE_FAULT_COUNT_EN
  ,
  output logic [15:0] fault_cnt
`endif
);
  hbridge_channel #(
    .DEAD_CYCLES(DEAD_CYCLES), .BLANK_CYCLES(BLANK_CYCLES),
    .OC_FILT(OC_FILT), .RETRY_CYCLES(RETRY_CYCLES)
  ) u_a (
    .clk(clk), .reset(reset), .cmd(in_cmd[1:0]), .oc(oc[0]),
    .out(IN[1:0]), .fault(fault[0]), .busy(busy[0])
`ifdef HBRIDGE_FAULT_COUNT_EN
    , .fault_cnt(fault_cnt[7:0])
`endif
  );
  hbridge_channel #(
    .DEAD_CYCLES(DEAD_CYCLES), .BLANK_CYCLES(BLANK_CYCLES),
    .OC_FILT(OC_FILT), .RETRY_CYCLES(RETRY_CYCLES)
  ) u_b (
    .clk(clk), .reset(reset), .cmd(in_cmd[3:2]), .oc(oc[1]),
    .out(IN[3:2]), .fault(fault[1]), .busy(busy[1])
`ifdef HBRIDGE_FAULT_COUNT_EN
    , .fault_cnt(fault_cnt[15:8])
`endif
  );
endmodule

// File: tb/tb_hbridge_guard.sv
// tb_hbridge_guard: directed checks of reset, dead-time, blanking, filtering, fault hold-off and async reset
module tb_hbridge_guard;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] in_cmd;
  logic [1:0] oc;
  logic [3:0] IN;
  logic [1:0] fault, busy;
`ifdef HBRIDGE_FAULT_COUNT_EN
  logic [15:0] fault_cnt;
`endif
  int passed = 0;
  int failed = 0;
  int total = 0;

  hbridge_guard #(
    .DEAD_CYCLES(4), .BLANK_CYCLES(8), .OC_FILT(3), .RETRY_CYCLES(20)
  ) dut (
    .clk(clk), .reset(reset), .in_cmd(in_cmd), .oc(oc),
    .IN(IN), .fault(fault), .busy(busy)
`ifdef HBRIDGE_FAULT_COUNT_EN
    , .fault_cnt(fault_cnt)
`endif
  );

  always #10 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    in_cmd = 4'b1010;
    oc = 2'b11;
    step(2);
    chk("rst_in", IN, 4'b0000);
    chk("rst_fault", fault, 2'b00);
    chk("rst_busy", busy, 2'b00);
    reset = 1'b1;
    oc = 2'b00;
    chk("rel_in0", IN, 4'b0000);
    step(1);
    chk("rel_in1", IN, 4'b1010);
    chk("rel_busy", busy, 2'b00);
    step(2);
    in_cmd = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("dead_in", IN, 4'b1000);
      chk("dead_busy", busy, 2'b01);
    end
    step(1);
    chk("rev_in", IN, 4'b1001);
    chk("rev_busy", busy, 2'b00);
    in_cmd = 4'b1010;
    step(4);
    chk("dead2_in", IN, 4'b1000);
    step(1);
    chk("fwd_in", IN, 4'b1010);
    oc = 2'b01;
    step(6);
    oc = 2'b00;
    step(6);
    chk("blank_fault", fault, 2'b00);
    chk("blank_in", IN, 4'b1010);
    oc = 2'b01;
    step(2);
    oc = 2'b00;
    step(4);
    chk("filt_fault", fault, 2'b00);
    chk("filt_in", IN, 4'b1010);
    oc = 2'b01;
    step(4);
    chk("pretrip_fault", fault, 2'b00);
    chk("pretrip_in", IN, 4'b1010);
    step(1);
    chk("trip_fault", fault, 2'b01);
    chk("trip_in", IN, 4'b1000);
    chk("trip_busy", busy, 2'b00);
    step(1);
    chk("hold_busy", busy, 2'b01);
    oc = 2'b00;
    step(24);
    chk("held_fault", fault, 2'b01);
    chk("held_in", IN, 4'b1000);
    chk("held_busy", busy, 2'b01);
    in_cmd = 4'b1000;
    step(1);
    chk("clr_fault", fault, 2'b00);
    chk("clr_in", IN, 4'b1000);
    chk("clr_busy", busy, 2'b00);
    in_cmd = 4'b1010;
    step(1);
    chk("rearm_in", IN, 4'b1010);
`ifdef HBRIDGE_FAULT_COUNT_EN
    chk("cnt_a1", fault_cnt, 16'h0001);
    reset = 1'b0;
    #1;
    chk("cnt_rst", fault_cnt, 16'h0000);
    step(1);
    reset = 1'b1;
    step(1);
    for (int i = 0; i < 3; i++) begin
      step(10);
      oc = 2'b10;
      step(8);
      oc = 2'b00;
      chk("b_trip", fault, 2'b10);
      in_cmd = 4'b0010;
      step(25);
      chk("b_clear", fault, 2'b00);
      in_cmd = 4'b1010;
      step(1);
    end
    chk("cnt_b3", fault_cnt, 16'h0300);
`endif
    in_cmd = 4'b1001;
    step(2);
    chk("middead_busy", busy, 2'b01);
    chk("middead_in", IN, 4'b1000);
    #4;
    reset = 1'b0;
    #1;
    chk("rstdead_in", IN, 4'b0000);
    chk("rstdead_busy", busy, 2'b00);
    step(1);
    reset = 1'b1;
    in_cmd = 4'b1010;
    step(1);
    chk("after_dead_in", IN, 4'b1010);
    step(10);
    oc = 2'b10;
    step(8);
    chk("midhold_fault", fault, 2'b10);
    chk("midhold_busy", busy, 2'b10);
    oc = 2'b00;
    #4;
    reset = 1'b0;
    #1;
    chk("rsthold_in", IN, 4'b0000);
    chk("rsthold_fault", fault, 2'b00);
    chk("rsthold_busy", busy, 2'b00);
`ifdef HBRIDGE_FAULT_COUNT_EN
    chk("rsthold_cnt", fault_cnt, 16'h0000);
`endif
    step(1);
    reset = 1'b1;
    step(1);
    chk("final_in", IN, 4'b1010);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
